nibble_word_packer: RTL and testbench

- Downstream consumer of a 4-bit registered flop bank: collects successive 4-bit nibbles into one wide word.
- The word is built as a concatenation of a constant header, zero padding and nibble part-selects.
- Uses a valid/ready handshake on both sides, a single output holding slot, and an explicit flush that emits partial words.
- Sits between the capture-register stage and the word-wide sink.

---
 rtl/nibble_packer_pkg.sv | 16 +
 rtl/nibble_packer_out_slot.sv | 82 ++++++++
 rtl/nibble_word_packer.sv | 102 ++++++++++
 tb/tb_nibble_word_packer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_packer_pkg.sv
// Shared constants, types and helpers for the nibble word packer.
package nibble_packer_pkg;

    localparam int unsigned NIB_W         = 4;
    localparam logic [3:0]  PAD_NIB       = 4'h0;
    localparam logic [3:0]  DEFAULT_HDR   = 4'hA;
    localparam int unsigned DEFAULT_HDR_W = 4;

    typedef logic [NIB_W-1:0] nib_t;

    // Width needed to hold a count from 0 to n inclusive.
    function automatic int unsigned len_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/nibble_packer_out_slot.sv
// Single-entry valid/ready holding register for packed words.
// Optional macro NIBBLE_PACKER_PARITY_EN adds a parity bit stored with the word.
module nibble_packer_out_slot
    import nibble_packer_pkg::*;
#(
    parameter int unsigned DATA_W = 20,
    parameter int unsigned LEN_W  = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [LEN_W-1:0]  len_o,
    output logic              slot_free_o
`ifdef NIBBLE_PACKER_PARITY_EN
    ,
    input  logic              parity_i,
    output logic              parity_o
`endif
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [LEN_W-1:0]  len_q, len_d;
`ifdef NIBBLE_PACKER_PARITY_EN
    logic              parity_q, parity_d;
`endif

    // A retiring word frees the slot in the same cycle, so loads can follow back-to-back.
    assign slot_free_o = !valid_q || ready_i;

    // Next-state: load has priority over retire; data only changes on load.
    always_comb begin
        valid_d  = valid_q;
        data_d   = data_q;
        len_d    = len_q;
`ifdef NIBBLE_PACKER_PARITY_EN
        parity_d = parity_q;
`endif
        if (load_i) begin
            valid_d  = 1'b1;
            data_d   = data_i;
            len_d    = len_i;
`ifdef NIBBLE_PACKER_PARITY_EN
            parity_d = parity_i;
`endif
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    // Slot state register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q  <= 1'b0;
            data_q   <= '0;
            len_q    <= '0;
`ifdef NIBBLE_PACKER_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            valid_q  <= valid_d;
            data_q   <= data_d;
            len_q    <= len_d;
`ifdef NIBBLE_PACKER_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign len_o   = len_q;
`ifdef NIBBLE_PACKER_PARITY_EN
    assign parity_o = parity_q;
`endif

endmodule

// File: rtl/nibble_word_packer.sv
// Packs successive 4-bit nibbles into {HDR, nibble[N-1..0]} words, first nibble in the LSBs.
// Flush emits a zero-padded partial word. Optional macro NIBBLE_PACKER_PARITY_EN adds
// out_parity (XOR over the payload nibbles).
module nibble_word_packer
    import nibble_packer_pkg::*;
#(
    parameter int unsigned      NIBBLES = 4,
    parameter int unsigned      HDR_W   = DEFAULT_HDR_W,
    parameter logic [HDR_W-1:0] HDR     = HDR_W'(DEFAULT_HDR)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [3:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          flush,
    output logic [HDR_W+4*NIBBLES-1:0]    out_data,
    output logic [len_w(NIBBLES)-1:0]     out_len,
    output logic                          out_valid,
    input  logic                          out_ready
`ifdef NIBBLE_PACKER_PARITY_EN
    ,
    output logic                          out_parity
`endif
);

    localparam int unsigned ASM_W  = NIB_W * NIBBLES;
    localparam int unsigned IDX_W  = $clog2(NIBBLES);
    localparam int unsigned LEN_W  = len_w(NIBBLES);
    localparam int unsigned WORD_W = HDR_W + ASM_W;

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [ASM_W-1:0] asm_q, asm_d, asm_next;
    logic [LEN_W-1:0] fill_cnt;
    nib_t             in_nib;
    logic             slot_free, last_nib, accept, complete, flush_fire, load;

    assign in_nib   = in_data;
    assign last_nib = (idx_q == IDX_W'(NIBBLES - 1));
    // Only the completing nibble needs a free slot; earlier ones go into the assembly.
    assign in_ready = !rst && (!last_nib || slot_free);
    assign accept   = in_valid && in_ready;

    // Assembly including any nibble accepted this cycle, and its fill count.
    always_comb begin
        asm_next = asm_q;
        if (accept) begin
            asm_next[idx_q*NIB_W +: NIB_W] = in_nib;
        end
        fill_cnt = LEN_W'(idx_q) + LEN_W'(accept);
    end

    assign complete   = accept && last_nib;
    assign flush_fire = flush && (fill_cnt != '0) && slot_free;
    assign load       = complete || flush_fire;

    // Next-state for fill index and assembly: a load restarts the word.
    always_comb begin
        idx_d = idx_q;
        asm_d = asm_q;
        if (load) begin
            idx_d = '0;
            asm_d = {NIBBLES{PAD_NIB}};
        end else if (accept) begin
            idx_d = idx_q + IDX_W'(1);
            asm_d = asm_next;
        end
    end

    // Fill index and assembly register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
            asm_q <= '0;
        end else begin
            idx_q <= idx_d;
            asm_q <= asm_d;
        end
    end

    nibble_packer_out_slot #(
        .DATA_W (WORD_W),
        .LEN_W  (LEN_W)
    ) u_out_slot (
        .clk_i       (clk),
        .rst_i       (rst),
        .load_i      (load),
        .data_i      ({HDR, asm_next}),
        .len_i       (fill_cnt),
        .ready_i     (out_ready),
        .valid_o     (out_valid),
        .data_o      (out_data),
        .len_o       (out_len),
        .slot_free_o (slot_free)
`ifdef NIBBLE_PACKER_PARITY_EN
        ,
        .parity_i    (^asm_next),
        .parity_o    (out_parity)
`endif
    );

endmodule

// File: tb/tb_nibble_word_packer.sv
// Directed self-checking bench for nibble_word_packer (NIBBLES=4, HDR=4'hA).
// Expected words go into a scoreboard queue as stimulus is driven and are compared on
// each output handshake. Define NIBBLE_PACKER_PARITY_EN to also check out_parity.
module tb_nibble_word_packer;

    typedef struct packed {
        logic [19:0] data;
        logic [2:0]  len;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        flush = 1'b0;
    logic [19:0] out_data;
    logic [2:0]  out_len;
    logic        out_valid;
    logic        out_ready = 1'b0;
`ifdef NIBBLE_PACKER_PARITY_EN
    logic        out_parity;
`endif

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    nibble_word_packer #(
        .NIBBLES (4),
        .HDR_W   (4),
        .HDR     (4'hA)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_data  (out_data),
        .out_len   (out_len),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef NIBBLE_PACKER_PARITY_EN
        ,
        .out_parity (out_parity)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one nibble and wait (bounded) until it is accepted; in_valid stays high.
    task automatic send(input logic [3:0] n);
        int k;
        in_valid = 1'b1;
        in_data  = n;
        #1;
        k = 0;
        while (!in_ready && k < 50) begin
            @(posedge clk);
            #2;
            k++;
        end
        checks++;
        assert (k < 50) passes++;
        else begin
            fails++;
            $error("FAIL send_timeout: observed in_ready=0 after %0d cycles expected 1", k);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [19:0] d, input logic [2:0] l);
        exp_t e;
        e.data = d;
        e.len  = l;
        sb.push_back(e);
    endtask

    // Scoreboard: every retired word must match the oldest expected entry.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            checks++;
            assert (sb.size() > 0) passes++;
            else begin
                fails++;
                $error("FAIL unexpected_word: observed %0h expected no word", out_data);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("word_data", out_data, e.data);
                check("word_len", out_len, e.len);
`ifdef NIBBLE_PACKER_PARITY_EN
                check("word_parity", out_parity, ^e.data[15:0]);
`endif
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: observed no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        // Reset state
        tick();
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_len", out_len, 0);
        check("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);

        // 1: full word back-to-back, one-cycle latency, one-cycle valid
        out_ready = 1'b1;
        push(20'hA4321, 3'd4);
        send(4'h1);
        send(4'h2);
        send(4'h3);
        check("t1_no_early_valid", out_valid, 0);
        send(4'h4);
        in_valid = 1'b0;
        check("t1_latency_valid", out_valid, 1);
        check("t1_data", out_data, 20'hA4321);
        tick();
        check("t1_valid_one_cycle", out_valid, 0);

        // 2: held slot stalls the completing nibble only
        out_ready = 1'b0;
        push(20'hA4321, 3'd4);
        push(20'hA8765, 3'd4);
        send(4'h1);
        send(4'h2);
        send(4'h3);
        send(4'h4);
        send(4'h5);
        send(4'h6);
        send(4'h7);
        in_data = 4'h8;
        #1;
        check("t2_stall_in_ready", in_ready, 0);
        check("t2_hold_valid", out_valid, 1);
        check("t2_hold_data", out_data, 20'hA4321);
        tick();
        tick();
        check("t2_stable_data", out_data, 20'hA4321);
        check("t2_stable_len", out_len, 4);
        check("t2_still_stalled", in_ready, 0);
        out_ready = 1'b1;
        send(4'h8);
        in_valid = 1'b0;
        check("t2_b2b_valid", out_valid, 1);
        check("t2_b2b_data", out_data, 20'hA8765);
        tick();
        check("t2_drain", out_valid, 0);

        // 3: flush a partial word, then a flush with nothing pending
        send(4'h5);
        send(4'h6);
        in_valid = 1'b0;
        push(20'hA0065, 3'd2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t3_flush_valid", out_valid, 1);
        check("t3_flush_len", out_len, 2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t3_empty_flush_ignored", out_valid, 0);
        tick();
        check("t3_still_idle", out_valid, 0);

        // 4: flush together with an accept includes that nibble and restarts the word
        send(4'h1);
        send(4'h2);
        push(20'hA0721, 3'd3);
        in_data = 4'h7;
        flush   = 1'b1;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        check("t4_flush_accept_data", out_data, 20'hA0721);
        check("t4_flush_accept_len", out_len, 3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t4_idx_cleared", out_valid, 0);

        // Flush coinciding with the completing nibble is a normal full word
        send(4'h1);
        send(4'h2);
        send(4'h3);
        push(20'hA4321, 3'd4);
        in_data = 4'h4;
        flush   = 1'b1;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        check("full_flush_len", out_len, 4);
        tick();

        // Single-nibble flush (parity 0 for 4'h3)
        send(4'h3);
        in_valid = 1'b0;
        push(20'hA0003, 3'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("single_flush_data", out_data, 20'hA0003);
        tick();

        // 5: mid-fill reset discards the partial word
        send(4'h9);
        send(4'h9);
        rst = 1'b1;
        #1;
        check("t5_rst_in_ready", in_ready, 0);
        tick();
        in_valid = 1'b0;
        check("t5_rst_out_valid", out_valid, 0);
        rst = 1'b0;
        push(20'hA4321, 3'd4);
        send(4'h1);
        send(4'h2);
        send(4'h3);
        send(4'h4);
        in_valid = 1'b0;
        check("t5_after_rst_data", out_data, 20'hA4321);
        tick();
        tick();
        tick();
        check("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
